// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: runs the product motor for a latched slot, then pays change greedily
// (quarters, dimes, nickels) through a single coin hopper, with timeout fault detection.
module vend_dispense_sequencer #(
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned EJECT_GAP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dispenser_go,
   input  logic [8:0] vend,
   input  logic [9:0] change,
   input  logic       motor_done,
   input  logic       hopper_ack,
   output logic       motor_en,
   output logic [8:0] motor_slot,
   output logic [2:0] coin_eject,
   output logic       dispenser_done_signal,
   output logic       busy,
   output logic [9:0] residue,
   output logic       fault
);

   localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;
   localparam int unsigned GapW = $clog2(EJECT_GAP) + 1;
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(EJECT_GAP - 1);

   localparam logic [2:0] CoinQuarter = 3'b100;
   localparam logic [2:0] CoinDime    = 3'b010;
   localparam logic [2:0] CoinNickel  = 3'b001;

   typedef enum logic [2:0] {StIdle, StMotor, StPay, StEject, StGap, StDone} state_e;

   state_e          state_q, state_d;
   logic            go_q;
   logic            start;
   logic [8:0]      slot_q, slot_d;
   logic [9:0]      rem_q, rem_d;
   logic [2:0]      coin_q, coin_d;
   logic [TmrW-1:0] tmr_q, tmr_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [9:0]      residue_q, residue_d;
   logic            fault_q, fault_d;
   logic [9:0]      coin_val;

   assign start = dispenser_go & ~go_q;

   always_comb begin
      if (coin_q[2]) begin
         coin_val = 10'd25;
      end else if (coin_q[1]) begin
         coin_val = 10'd10;
      end else begin
         coin_val = 10'd5;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         go_q      <= 1'b0;
         slot_q    <= '0;
         rem_q     <= '0;
         coin_q    <= '0;
         tmr_q     <= '0;
         gap_q     <= '0;
         residue_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         go_q      <= dispenser_go;
         slot_q    <= slot_d;
         rem_q     <= rem_d;
         coin_q    <= coin_d;
         tmr_q     <= tmr_d;
         gap_q     <= gap_d;
         residue_q <= residue_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      rem_d     = rem_q;
      coin_d    = coin_q;
      residue_d = residue_q;
      fault_d   = fault_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               slot_d    = vend;
               rem_d     = change;
               fault_d   = 1'b0;
               residue_d = '0;
               state_d   = (vend != 9'd0) ? StMotor : StPay;
            end
         end
         StMotor: begin
            if (motor_done) begin
               state_d = StPay;
            end else if (tmr_q == TmrLast) begin
               fault_d = 1'b1;
               state_d = StPay;
            end
         end
         StPay: begin
            if (rem_q >= 10'd25) begin
               coin_d  = CoinQuarter;
               state_d = StEject;
            end else if (rem_q >= 10'd10) begin
               coin_d  = CoinDime;
               state_d = StEject;
            end else if (rem_q >= 10'd5) begin
               coin_d  = CoinNickel;
               state_d = StEject;
            end else begin
               residue_d = rem_q;
               state_d   = StDone;
            end
         end
         StEject: begin
            if (hopper_ack) begin
               rem_d   = rem_q - coin_val;
               state_d = StGap;
            end else if (tmr_q == TmrLast) begin
               // Unacknowledged coin stays in the unpaid amount.
               fault_d   = 1'b1;
               residue_d = rem_q;
               state_d   = StDone;
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               state_d = StPay;
            end
         end
         StDone: begin
            if (!dispenser_go) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Counters only advance while dwelling in their state, so they restart on every entry.
   always_comb begin
      tmr_d = '0;
      gap_d = '0;
      if ((state_q == StMotor || state_q == StEject) && state_d == state_q) begin
         tmr_d = tmr_q + 1'b1;
      end
      if (state_q == StGap && state_d == StGap) begin
         gap_d = gap_q + 1'b1;
      end
   end

   always_comb begin
      motor_en              = (state_q == StMotor);
      motor_slot            = (state_q == StMotor) ? slot_q : 9'd0;
      coin_eject            = (state_q == StEject) ? coin_q : 3'd0;
      dispenser_done_signal = (state_q == StDone);
      busy                  = (state_q != StIdle);
      residue               = residue_q;
      fault                 = fault_q;
   end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Self-checking bench for vend_dispense_sequencer: table of dispense transactions plus
// hand-written sequences for latency, busy-time restart and asynchronous reset.
module tb_vend_dispense_sequencer;

   localparam int TIMEOUT   = 1000;
   localparam int EJECT_GAP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       dispenser_go;
   logic [8:0] vend;
   logic [9:0] change;
   logic       motor_done;
   logic       hopper_ack;
   logic       motor_en;
   logic [8:0] motor_slot;
   logic [2:0] coin_eject;
   logic       dispenser_done_signal;
   logic       busy;
   logic [9:0] residue;
   logic       fault;

   int n_tests = 0;
   int n_fail  = 0;

   vend_dispense_sequencer #(
      .TIMEOUT   (TIMEOUT),
      .EJECT_GAP (EJECT_GAP)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .dispenser_go          (dispenser_go),
      .vend                  (vend),
      .change                (change),
      .motor_done            (motor_done),
      .hopper_ack            (hopper_ack),
      .motor_en              (motor_en),
      .motor_slot            (motor_slot),
      .coin_eject            (coin_eject),
      .dispenser_done_signal (dispenser_done_signal),
      .busy                  (busy),
      .residue               (residue),
      .fault                 (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] vend;
      logic [9:0] change;
      int         motor_delay;  // 0 = motor_done never arrives
      int         ack_delay;
      int         withhold;     // request index (1-based) never acked, 0 = none
      int         exp_motor;
      int         exp_q;
      int         exp_d;
      int         exp_n;
      int         exp_res;
      int         exp_fault;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int motor_cyc = 0;
      int q = 0;
      int d = 0;
      int n = 0;
      int req_cyc = 0;
      int req_idx = 0;
      int idle_gap = 0;
      int cycles = 0;
      bit slot_ok = 1'b1;
      bit onehot_ok = 1'b1;
      bit gap_ok = 1'b1;
      bit seen_coin = 1'b0;
      bit in_req = 1'b0;
      bit got_done = 1'b0;
      bit held_ok = 1'b1;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      vend = v.vend;
      change = v.change;
      dispenser_go = 1'b1;
      while (cycles < 60000) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            vend = 9'h0aa;
            change = 10'd999;
         end
         motor_done = 1'b0;
         hopper_ack = 1'b0;
         if (dispenser_done_signal) begin
            got_done = 1'b1;
            break;
         end
         if (motor_en) begin
            motor_cyc++;
            if (motor_slot !== v.vend) slot_ok = 1'b0;
            if (v.motor_delay != 0 && motor_cyc == v.motor_delay) motor_done = 1'b1;
         end else if (motor_slot !== 9'd0) begin
            slot_ok = 1'b0;
         end
         if (coin_eject !== 3'd0) begin
            if (!$onehot(coin_eject)) onehot_ok = 1'b0;
            if (!in_req) begin
               in_req = 1'b1;
               req_cyc = 0;
               req_idx++;
               if (coin_eject == 3'b100) q++;
               if (coin_eject == 3'b010) d++;
               if (coin_eject == 3'b001) n++;
               if (seen_coin && idle_gap != EJECT_GAP + 1) gap_ok = 1'b0;
            end
            req_cyc++;
            if (req_cyc == v.ack_delay && req_idx != v.withhold) hopper_ack = 1'b1;
         end else begin
            if (in_req) begin
               in_req = 1'b0;
               seen_coin = 1'b1;
               idle_gap = 0;
            end
            idle_gap++;
         end
      end
      check({tag, "_done_reached"}, got_done, 1);
      check({tag, "_motor_cycles"}, motor_cyc, v.exp_motor);
      check({tag, "_motor_slot"}, slot_ok, 1);
      check({tag, "_quarters"}, q, v.exp_q);
      check({tag, "_dimes"}, d, v.exp_d);
      check({tag, "_nickels"}, n, v.exp_n);
      check({tag, "_onehot"}, onehot_ok, 1);
      check({tag, "_gap"}, gap_ok, 1);
      check({tag, "_residue"}, residue, v.exp_res);
      check({tag, "_fault"}, fault, v.exp_fault);
      repeat (3) begin
         @(negedge clk);
         if (dispenser_done_signal !== 1'b1 || busy !== 1'b1) held_ok = 1'b0;
      end
      check({tag, "_done_held"}, held_ok, 1);
      dispenser_go = 1'b0;
      @(negedge clk);
      check({tag, "_done_drop"}, dispenser_done_signal, 0);
      check({tag, "_busy_drop"}, busy, 0);
      check({tag, "_residue_idle"}, residue, v.exp_res);
   endtask

   initial begin
      bit found;
      vecs[0] = '{9'h123, 10'd90,   5, 2, 0, 5,       3,  1, 1, 0,  0};
      vecs[1] = '{9'h000, 10'd7,    0, 2, 0, 0,       0,  0, 1, 2,  0};
      vecs[2] = '{9'h000, 10'd1023, 0, 2, 0, 0,       40, 2, 0, 3,  0};
      vecs[3] = '{9'h045, 10'd10,   0, 2, 0, TIMEOUT, 0,  1, 0, 0,  1};
      vecs[4] = '{9'h000, 10'd35,   0, 2, 2, 0,       1,  1, 0, 10, 1};
      vecs[5] = '{9'h000, 10'd0,    0, 2, 0, 0,       0,  0, 0, 0,  0};
      vecs[6] = '{9'h1ff, 10'd4,    1, 1, 0, 1,       0,  0, 0, 4,  0};

      reset = 1'b1;
      dispenser_go = 1'b0;
      vend = '0;
      change = '0;
      motor_done = 1'b0;
      hopper_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {motor_en, motor_slot, coin_eject, dispenser_done_signal, busy,
                              residue, fault}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Zero-change refund: done two clock edges after go is sampled.
      vend = 9'd0;
      change = 10'd0;
      dispenser_go = 1'b1;
      @(negedge clk);
      check("lat_busy", busy, 1);
      check("lat_done_early", dispenser_done_signal, 0);
      @(negedge clk);
      check("lat_done", dispenser_done_signal, 1);
      dispenser_go = 1'b0;
      @(negedge clk);
      check("lat_done_drop", dispenser_done_signal, 0);

      // Restart attempt while ejecting must not relatch; then async reset mid-eject.
      change = 10'd50;
      dispenser_go = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (coin_eject != 3'd0) found = 1'b1;
      end
      check("b_first_coin", coin_eject, 3'b100);
      dispenser_go = 1'b0;
      @(negedge clk);
      vend = 9'h1aa;
      change = 10'd5;
      dispenser_go = 1'b1;
      @(negedge clk);
      check("b_no_motor", motor_en, 0);
      hopper_ack = 1'b1;
      @(negedge clk);
      hopper_ack = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (coin_eject != 3'd0) found = 1'b1;
      end
      check("b_no_relatch", coin_eject, 3'b100);
      #2 reset = 1'b1;
      #1;
      check("b_reset_coin", coin_eject, 0);
      check("b_reset_busy", busy, 0);
      check("b_reset_misc", {motor_en, dispenser_done_signal, residue, fault}, 0);
      dispenser_go = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("b_after_reset_idle", busy, 0);

      // Async reset while the motor runs.
      vend = 9'h0f0;
      change = 10'd0;
      dispenser_go = 1'b1;
      @(negedge clk);
      check("c_motor_en", motor_en, 1);
      check("c_motor_slot", motor_slot, 9'h0f0);
      #2 reset = 1'b1;
      #1;
      check("c_reset_motor", {motor_en, motor_slot, busy}, 0);
      dispenser_go = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
